// File: rtl/cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator (cmp_serial).
// Holds the FSM state enum, the result code with its flag decoder, and the
// index-width function used to size the bit-index counter.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   // RES_EQ doubles as "no difference seen yet" while scanning: if nothing
   // ever differs, that is exactly the final answer.
   typedef enum logic [1:0] {
      RES_LT = 2'd0,
      RES_EQ = 2'd1,
      RES_GT = 2'd2
   } res_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } flags_t;

   // Number of bits needed to hold values 0..value-1 (value >= 2).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // One-hot flag decode of a result code.
   function automatic flags_t decode_res(input res_t r);
      flags_t f;
      f = '0;
      case (r)
         RES_LT:  f.lt = 1'b1;
         RES_GT:  f.gt = 1'b1;
         default: f.eq = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/cmp_idx_ctr.sv
// Loadable, non-wrapping down-counter that walks the bit index of the
// serial comparator from MSB to LSB; o_zero marks the last bit.
module cmp_idx_ctr #(
   parameter int IW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_load,
   input  logic [IW-1:0] i_load_val,
   input  logic          i_dec,
   output logic [IW-1:0] o_count,
   output logic          o_zero
);

   logic [IW-1:0] r_count;

   // Load takes priority over decrement; decrement saturates at zero.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/cmp_serial.sv
// Serial MSB-first magnitude comparator, signed or unsigned, with a
// start/busy/done handshake and held one-hot lt/eq/gt flags.
// Build option: define CMP_EARLY_EXIT_EN to leave the scan on the first
// differing bit; results are identical either way, only latency changes.
module cmp_serial
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int IW = clog2(WIDTH);

`ifdef CMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   state_t           r_state;
   res_t             r_res;
   flags_t           r_flags;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;

   logic [IW-1:0]    w_idx;
   logic             w_idx_zero;
   logic             w_accept;
   logic             w_a_bit;
   logic             w_b_bit;
   res_t             w_res_next;
   logic             w_scan_end;

   // Start is honoured in IDLE and FIN; while scanning it is dropped.
   assign w_accept = start && (r_state != SCAN);

   cmp_idx_ctr #(.IW(IW)) u_idx_ctr (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val (IW'(WIDTH - 1)),
      .i_dec      (r_state == SCAN),
      .o_count    (w_idx),
      .o_zero     (w_idx_zero)
   );

   // Capture operands on acceptance; in signed mode flipping the MSB maps
   // two's complement onto offset binary so one unsigned scan serves both.
   // NOTE: operand registers have no reset; they are always written before use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
         r_b <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
      end
   end

   assign w_a_bit = r_a[w_idx];
   assign w_b_bit = r_b[w_idx];

   // Decision after this bit: the first differing bit sticks.
   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      w_res_next = r_res;
      if (r_res == RES_EQ) begin
         if (w_a_bit && !w_b_bit) begin
            w_res_next = RES_GT;
         end else if (!w_a_bit && w_b_bit) begin
            w_res_next = RES_LT;
         end
      end
   end

   assign w_scan_end = w_idx_zero || (EARLY_EXIT && (w_res_next != RES_EQ));

   // Control FSM with registered busy/done/flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_res   <= RES_EQ;
         r_flags <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= SCAN;
                  r_res   <= RES_EQ;
                  r_busy  <= 1'b1;
               end
            end
            SCAN: begin
               r_res <= w_res_next;
               if (w_scan_end) begin
                  r_state <= FIN;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_flags <= decode_res(w_res_next);
               end
            end
            FIN: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= SCAN;
                  r_res   <= RES_EQ;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign lt   = r_flags.lt;
   assign eq   = r_flags.eq;
   assign gt   = r_flags.gt;

endmodule

// File: tb/tb_cmp_serial.sv
// Self-checking bench for cmp_serial: a WIDTH=4 and a WIDTH=32 instance are
// exercised with directed and random operands and compared against an
// arithmetic reference model (signed/unsigned comparison plus the latency
// formula). Honours CMP_EARLY_EXIT_EN when the build defines it.
module tb_cmp_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start4, sm4;
   logic [3:0]  a4, b4;
   logic        busy4, done4, lt4, eq4, gt4;
   logic        start32, sm32;
   logic [31:0] a32, b32;
   logic        busy32, done32, lt32, eq32, gt32;

   int errors = 0;
   int checks = 0;

   cmp_serial #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
      .a(a4), .b(b4), .busy(busy4), .done(done4),
      .lt(lt4), .eq(eq4), .gt(gt4)
   );

   cmp_serial #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(reset), .start(start32), .signed_mode(sm32),
      .a(a32), .b(b32), .busy(busy32), .done(done32),
      .lt(lt32), .eq(eq32), .gt(gt32)
   );

   // Reference: {lt,eq,gt} from plain integer comparison of w-bit operands.
   function automatic logic [2:0] model_flags(input logic [63:0] a, input logic [63:0] b,
                                              input logic s, input int w);
      logic [63:0] mask;
      longint sa, sb;
      mask = (64'd1 << w) - 64'd1;
      sa = longint'(a & mask);
      sb = longint'(b & mask);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      if (sa < sb) return 3'b100;
      if (sa == sb) return 3'b010;
      return 3'b001;
   endfunction

   // Reference latency in edges, counting the start-sampling edge.
   function automatic int model_lat(input logic [63:0] a, input logic [63:0] b, input int w);
      logic [63:0] d;
      d = (a ^ b) & ((64'd1 << w) - 64'd1);
      if (d == 64'd0) return w + 1;
`ifdef CMP_EARLY_EXIT_EN
      for (int k = w - 1; k >= 0; k--) begin
         if (d[k]) return (w - 1 - k) + 2;
      end
`endif
      return w + 1;
   endfunction

   function automatic logic [4:0] obs(input int w);
      if (w == 4) return {busy4, done4, lt4, eq4, gt4};
      return {busy32, done32, lt32, eq32, gt32};
   endfunction

   task automatic drive(input int w, input logic st, input logic [63:0] a,
                        input logic [63:0] b, input logic s);
      if (w == 4) begin
         start4 = st; a4 = a[3:0]; b4 = b[3:0]; sm4 = s;
      end else begin
         start32 = st; a32 = a[31:0]; b32 = b[31:0]; sm32 = s;
      end
   endtask

   // One complete operation: start pulse, scramble inputs, await done.
   task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input string name);
      logic [2:0] exp_f;
      logic [4:0] o;
      int exp_lat;
      int lat;
      exp_f   = model_flags(a, b, s, w);
      exp_lat = model_lat(a, b, w);
      drive(w, 1'b1, a, b, s);
      @(posedge clk);
      @(negedge clk);
      drive(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      lat = 1;
      o = obs(w);
      checks++;
      if (o[4] !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_start: got %b expected 1", name, o[4]);
      end
      while (o[3] !== 1'b1 && lat < 200) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         o = obs(w);
      end
      checks++;
      if (o[3] !== 1'b1) begin
         errors++;
         $display("FAIL %s done_timeout: no done within %0d cycles, expected at %0d", name, lat, exp_lat);
      end else begin
         checks++;
         if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
         end
         checks++;
         if (o[2:0] !== exp_f) begin
            errors++;
            $display("FAIL %s flags(lt,eq,gt): got %b expected %b", name, o[2:0], exp_f);
         end
         checks++;
         if (o[4] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done_cycle: got %b expected 0", name, o[4]);
         end
         @(posedge clk);
         @(negedge clk);
         o = obs(w);
         checks++;
         if (o[3:0] !== {1'b0, exp_f}) begin
            errors++;
            $display("FAIL %s done_pulse_hold(done,lt,eq,gt): got %b expected %b", name, o[3:0], {1'b0, exp_f});
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(4, 1'b0, 64'd0, 64'd0, 1'b0);
      drive(32, 1'b0, 64'd0, 64'd0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs(4) !== 5'b0) begin
         errors++;
         $display("FAIL reset_w4(busy,done,lt,eq,gt): got %b expected 00000", obs(4));
      end
      checks++;
      if (obs(32) !== 5'b0) begin
         errors++;
         $display("FAIL reset_w32(busy,done,lt,eq,gt): got %b expected 00000", obs(32));
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs(4) !== 5'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b expected 00000", obs(4));
      end
   endtask

   task automatic test_directed();
      run_op(4, 64'b1101, 64'b0010, 1'b1, "s_m3_vs_p2");
      run_op(4, 64'b1101, 64'b0010, 1'b0, "u_13_vs_2");
      run_op(4, 64'b1000, 64'b0111, 1'b1, "s_min_vs_max");
      run_op(4, 64'b1000, 64'b0111, 1'b0, "u_8_vs_7");
      run_op(4, 64'b0111, 64'b1000, 1'b1, "s_max_vs_min");
      run_op(4, 64'b1010, 64'b1010, 1'b1, "s_equal");
      run_op(4, 64'b1010, 64'b1010, 1'b0, "u_equal");
      run_op(4, 64'b0100, 64'b0010, 1'b1, "s_diff_bit2");
      run_op(4, 64'b0001, 64'b0000, 1'b1, "s_diff_bit0");
      run_op(4, 64'b1111, 64'b0000, 1'b0, "u_15_vs_0");
      run_op(4, 64'b1111, 64'b0000, 1'b1, "s_m1_vs_0");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         run_op(4, 64'($urandom_range(15)), 64'($urandom_range(15)), 1'($urandom), "rand_w4");
      end
   endtask

   // A start pulse mid-scan must neither disturb nor queue anything.
   task automatic test_ignore_start();
      int dones;
      logic [2:0] seen;
      dones = 0;
      seen  = 3'b000;
      drive(4, 1'b1, 64'b1010, 64'b1010, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(4, 1'b0, 64'b0000, 64'b0000, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(4, 1'b1, 64'b0001, 64'b1110, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(4, 1'b0, 64'b0001, 64'b1110, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (done4 === 1'b1) begin
            dones++;
            seen = {lt4, eq4, gt4};
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL ignore_start_done_count: got %0d expected 1", dones);
      end
      checks++;
      if (seen !== 3'b010) begin
         errors++;
         $display("FAIL ignore_start_flags(lt,eq,gt): got %b expected 010", seen);
      end
   endtask

   // Start held high: each done cycle accepts the next operand pair.
   task automatic test_back_to_back();
      logic [63:0] ca, cb, na, nb;
      logic cs, ns;
      logic [2:0] exp_f;
      int lat;
      ca = 64'($urandom_range(15));
      cb = 64'($urandom_range(15));
      cs = 1'($urandom);
      drive(4, 1'b1, ca, cb, cs);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         na = 64'($urandom_range(15));
         nb = 64'($urandom_range(15));
         ns = 1'($urandom);
         drive(4, 1'b1, na, nb, ns);
         lat = 1;
         while (done4 !== 1'b1 && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
         end
         exp_f = model_flags(ca, cb, cs, 4);
         checks++;
         if (done4 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d done_timeout: waited %0d cycles", i, lat);
         end else begin
            checks++;
            if (lat != model_lat(ca, cb, 4)) begin
               errors++;
               $display("FAIL b2b_%0d period: got %0d expected %0d", i, lat, model_lat(ca, cb, 4));
            end
            checks++;
            if ({lt4, eq4, gt4} !== exp_f) begin
               errors++;
               $display("FAIL b2b_%0d flags(lt,eq,gt): got %b expected %b", i, {lt4, eq4, gt4}, exp_f);
            end
         end
         ca = na;
         cb = nb;
         cs = ns;
         if (i == 7) drive(4, 1'b0, na, nb, ns);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset in the middle of a scan clears everything and emits no done.
   task automatic test_reset_mid_op();
      int dones;
      run_op(4, 64'b0100, 64'b0010, 1'b1, "pre_abort");
      drive(4, 1'b1, 64'b0110, 64'b0110, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(4, 1'b0, 64'b0000, 64'b0000, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs(4) !== 5'b0) begin
         errors++;
         $display("FAIL abort_state(busy,done,lt,eq,gt): got %b expected 00000", obs(4));
      end
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done4 === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
      end
      run_op(4, 64'b1101, 64'b0010, 1'b1, "post_abort");
   endtask

   task automatic test_width_sweep();
      run_op(32, 64'h8000_0000, 64'h7FFF_FFFF, 1'b1, "w32_signed");
      run_op(32, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, "w32_unsigned");
      run_op(32, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b1, "w32_equal");
      for (int i = 0; i < 4; i++) begin
         run_op(32, 64'($urandom), 64'($urandom), 1'($urandom), "rand_w32");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_op();
      test_width_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
